// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset vector,
// fetch FSM states and the ebreak encoding.
package riscv_pkg;

    localparam int          INSTR_SIZE       = 32;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [31:0] EBREAK           = 32'h0010_0073;

    // Fetch sequencer: request, wait for the word, present it, or stop for good.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } ifu_state_e;

    // A fetch target must be word aligned; only the two low address bits matter.
    function automatic logic is_misaligned(input logic [1:0] addr_low);
        return addr_low != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_if.sv
// Instruction memory request/response channel between the fetch unit
// (master) and the instruction memory (slave).
interface ifu_if #(
    parameter int INSTR_SIZE = riscv_pkg::INSTR_SIZE
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [63:0]           imem_addr;
    logic                  imem_rsp_valid;
    logic [INSTR_SIZE-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: issues one fetch at a time, holds the returned word
// for the decode stage, and computes the next pc from the decode feedback
// (sequential, redirect, or halt on ebreak / misaligned target).
module ifu
    import riscv_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          INSTR_SIZE = riscv_pkg::INSTR_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    ifu_if.master                 imem,
    output logic [INSTR_SIZE-1:0] instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [63:0]           pc_o,
    input  logic                  redirect_en,
    input  logic [63:0]           redirect_pc,
    input  logic                  ebreak,
    output logic                  halted,
    output logic                  fetch_misalign
);

    ifu_state_e            state_reg, state_next;
    logic [63:0]           pc_reg, pc_next;
    logic [INSTR_SIZE-1:0] instr_reg, instr_next;
    logic [63:0]           pc_o_reg, pc_o_next;
    logic                  misalign_reg, misalign_next;

    // State and datapath registers; reset is asynchronous so outputs clear at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= FETCH;
            pc_reg       <= RESET_PC;
            instr_reg    <= '0;
            pc_o_reg     <= '0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            pc_o_reg     <= pc_o_next;
            misalign_reg <= misalign_next;
        end
    end

    // Next-state and next-pc decisions; feedback from decode only matters at accept.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        pc_o_next     = pc_o_reg;
        misalign_next = misalign_reg;

        case (state_reg)
            FETCH: begin
                if (imem.imem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // Responses are only meaningful here; anything arriving in other
                // states is a stale or spurious beat and is dropped.
                if (imem.imem_rsp_valid) begin
                    instr_next = imem.imem_rsp_data;
                    pc_o_next  = pc_reg;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    if (ebreak) begin
                        // ebreak wins over any redirect; pc is left where it was.
                        state_next = HALT;
                    end else if (redirect_en && is_misaligned(redirect_pc[1:0])) begin
                        misalign_next = 1'b1;
                        state_next    = HALT;
                    end else begin
                        pc_next    = redirect_en ? redirect_pc : (pc_reg + 64'd4);
                        state_next = FETCH;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Request is masked while reset is held so nothing is issued during reset.
    assign imem.imem_req_valid = (state_reg == FETCH) && !rst;
    assign imem.imem_addr      = pc_reg;

    assign instr          = instr_reg;
    assign pc_o           = pc_o_reg;
    assign instr_valid    = (state_reg == HOLD);
    assign halted         = (state_reg == HALT);
    assign fetch_misalign = misalign_reg;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for the fetch unit: a transaction-level model of the
// fetch stream checked every cycle, plus directed scenarios with literal values.
module tb_ifu;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [63:0] pc_o;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        ebreak;
    logic        halted;
    logic        fetch_misalign;

    int checks   = 0;
    int failures = 0;

    // memory behaviour knobs, written by the stimulus process
    int   mem_delay;
    logic spur;

    ifu_if if0 ();

    ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (if0),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .pc_o           (pc_o),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .ebreak         (ebreak),
        .halted         (halted),
        .fetch_misalign (fetch_misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Contents of instruction memory: a nop at the reset vector, address-tagged words elsewhere.
    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        return {addr[26:2], 7'h13};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory: accepts a request, answers after mem_delay extra cycles,
    // optionally drives junk beats (spur) when nothing is pending.
    initial begin
        logic        hs;
        logic [63:0] hs_addr;
        logic        pend;
        logic [63:0] paddr;
        int          wcnt;
        pend = 1'b0;
        paddr = '0;
        wcnt = 0;
        if0.imem_rsp_valid = 1'b0;
        if0.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            hs      = (rst === 1'b0) && if0.imem_req_valid && if0.imem_req_ready;
            hs_addr = if0.imem_addr;
            @(posedge clk);
            #2;
            if (rst) begin
                pend = 1'b0;
            end else if (hs) begin
                pend  = 1'b1;
                paddr = hs_addr;
                wcnt  = mem_delay;
            end
            if (pend && wcnt == 0) begin
                if0.imem_rsp_valid = 1'b1;
                if0.imem_rsp_data  = mem_word(paddr);
                pend = 1'b0;
            end else begin
                if (pend) wcnt--;
                if0.imem_rsp_valid = spur;
                if0.imem_rsp_data  = 32'hdead_beef;
            end
        end
    end

    // Transaction model: which pc is owed, whether a fetch is outstanding, whether
    // its word has arrived, and the halt/misalign flags. Checked every negedge.
    initial begin
        logic [63:0] m_pc;
        logic        m_busy, m_rsp, m_halted, m_mis;
        m_pc = RESET_PC_DEFAULT;
        m_busy = 1'b0; m_rsp = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_req_valid", if0.imem_req_valid, 0);
                chk("rst_instr_valid", instr_valid, 0);
                chk("rst_instr", instr, 0);
                chk("rst_pc_o", pc_o, 0);
                chk("rst_halted", halted, 0);
                chk("rst_misalign", fetch_misalign, 0);
                m_pc = RESET_PC_DEFAULT;
                m_busy = 1'b0; m_rsp = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
            end else begin
                chk("halted", halted, m_halted);
                chk("misalign", fetch_misalign, m_mis);
                chk("req_valid", if0.imem_req_valid, !m_busy && !m_halted);
                if (!m_busy && !m_halted) chk("imem_addr", if0.imem_addr, m_pc);
                chk("instr_valid", instr_valid, m_rsp);
                if (m_rsp) begin
                    chk("pc_o", pc_o, m_pc);
                    chk("instr", instr, mem_word(m_pc));
                end
                if (!m_busy && !m_halted) begin
                    if (if0.imem_req_ready) m_busy = 1'b1;
                end else if (m_busy && !m_rsp) begin
                    if (if0.imem_rsp_valid) m_rsp = 1'b1;
                end else if (m_rsp && instr_ready) begin
                    $display("accept pc=%h instr=%h redirect_en=%0d redirect_pc=%h ebreak=%0d",
                             m_pc, mem_word(m_pc), redirect_en, redirect_pc, ebreak);
                    if (ebreak) begin
                        m_halted = 1'b1;
                    end else if (redirect_en && redirect_pc[1:0] != 2'b00) begin
                        m_halted = 1'b1;
                        m_mis    = 1'b1;
                    end else begin
                        m_pc = redirect_en ? redirect_pc : m_pc + 64'd4;
                    end
                    m_busy = 1'b0;
                    m_rsp  = 1'b0;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with instr_valid high or after a bounded wait.
    task automatic wait_hold();
        int n = 0;
        while (!instr_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!instr_valid) begin
            failures++;
            $display("FAIL wait_hold: got instr_valid=0 expected 1 within 100 cycles at %0t", $time);
        end
    endtask

    task automatic accept(input logic re, input logic [63:0] rpc, input logic eb);
        wait_hold();
        instr_ready = 1'b1;
        redirect_en = re;
        redirect_pc = rpc;
        ebreak      = eb;
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        redirect_en = 1'b0;
        ebreak      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        if0.imem_req_ready = 1'b1;
        instr_ready = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        ebreak = 1'b0;
        spur = 1'b0;
        mem_delay = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("lit_rst_req", if0.imem_req_valid, 0);
        chk("lit_rst_halted", halted, 0);

        // boot: zero-latency memory, decode always ready
        @(posedge clk); #1;
        rst = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        chk("lit_boot_req", if0.imem_req_valid, 1);
        chk("lit_boot_addr", if0.imem_addr, 64'h8000_0000);
        @(negedge clk);
        chk("lit_c2_valid", instr_valid, 0);
        @(negedge clk);
        chk("lit_c3_valid", instr_valid, 1);
        chk("lit_c3_instr", instr, 32'h0000_0013);
        chk("lit_c3_pc_o", pc_o, 64'h8000_0000);
        @(negedge clk);
        chk("lit_c4_req", if0.imem_req_valid, 1);
        chk("lit_c4_addr", if0.imem_addr, 64'h8000_0004);
        @(posedge clk); #1;
        instr_ready = 1'b0;

        // stall in HOLD for 5 cycles with ignored redirect/ebreak pulses
        wait_hold();
        for (int i = 0; i < 5; i++) begin
            redirect_en = (i % 2 == 0);
            redirect_pc = 64'h8000_0200;
            ebreak      = (i == 2);
            @(negedge clk);
            chk("lit_hold_req", if0.imem_req_valid, 0);
            chk("lit_hold_pc_o", pc_o, 64'h8000_0004);
            @(posedge clk); #1;
        end
        redirect_en = 1'b0;
        ebreak = 1'b0;
        accept(1'b0, 64'h0, 1'b0);

        // taken redirect from 0x80000008
        accept(1'b1, 64'h8000_0100, 1'b0);
        chk("lit_redir_req", if0.imem_req_valid, 1);
        chk("lit_redir_addr", if0.imem_addr, 64'h8000_0100);

        // slow memory and backpressure on the request
        mem_delay = 2;
        if0.imem_req_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if0.imem_req_ready = 1'b1;
        accept(1'b0, 64'h0, 1'b0);
        chk("lit_seq_addr", if0.imem_addr, 64'h8000_0104);
        mem_delay = 0;

        // pc wraps modulo 2^64
        accept(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        chk("lit_top_addr", if0.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        accept(1'b0, 64'h0, 1'b0);
        chk("lit_wrap_addr", if0.imem_addr, 64'h0);

        // ebreak beats redirect
        accept(1'b1, 64'h8000_0040, 1'b1);
        chk("lit_ebreak_halted", halted, 1);
        chk("lit_ebreak_req", if0.imem_req_valid, 0);
        chk("lit_ebreak_mis", fetch_misalign, 0);
        repeat (4) begin @(posedge clk); #1; end
        chk("lit_halt_req", if0.imem_req_valid, 0);
        chk("lit_halt_valid", instr_valid, 0);

        // misaligned redirect target
        rst = 1'b1;
        #1;
        chk("lit_rst2_halted", halted, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        accept(1'b1, 64'h8000_0102, 1'b0);
        chk("lit_mis_flag", fetch_misalign, 1);
        chk("lit_mis_halted", halted, 1);
        chk("lit_mis_req", if0.imem_req_valid, 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("lit_mis_req_later", if0.imem_req_valid, 0);

        // reset in the middle of WAIT, then spurious beats during FETCH
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        accept(1'b0, 64'h0, 1'b0);
        mem_delay = 3;
        @(posedge clk); #1;
        chk("lit_wait_req", if0.imem_req_valid, 0);
        chk("lit_wait_pc_o", pc_o, 64'h8000_0000);
        rst = 1'b1;
        #1;
        chk("lit_arst_req", if0.imem_req_valid, 0);
        chk("lit_arst_pc_o", pc_o, 64'h0);
        chk("lit_arst_instr", instr, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        if0.imem_req_ready = 1'b0;
        spur = 1'b1;
        mem_delay = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("lit_spur_valid", instr_valid, 0);
            chk("lit_spur_addr", if0.imem_addr, 64'h8000_0000);
            @(posedge clk); #1;
        end
        if0.imem_req_ready = 1'b1;
        spur = 1'b0;
        wait_hold();
        chk("lit_refetch_pc_o", pc_o, 64'h8000_0000);
        chk("lit_refetch_instr", instr, 32'h0000_0013);
        accept(1'b0, 64'h0, 1'b0);
        accept(1'b0, 64'h0, 1'b0);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
